gmsk_v1_mem_arbiter: RTL
========================

// Module: gmsk_v1_mem_arbiter
// PURPOSE
//   Shares the single-port on-chip SRAM in gmsk_v1_soc between the CV32E40P instruction-fetch
//   and data OBI ports. One grant per cycle, fixed data priority with an instr anti-starvation
//   timer, 1-cycle response routing, address range check, saturating contention counter.
// PARAMETERS
//   MEM_WORDS  4096          SRAM depth in 32-bit words (power of 2); AW = $clog2(MEM_WORDS)
//   BASE_ADDR  32'h0000_0000 byte address of SRAM word 0 (aligned to 4*MEM_WORDS)
//   MAX_WAIT   4             consecutive lost cycles after which instr wins arbitration (1..15)
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   asynchronous reset, active-high
//   instr_req_i     in   1   instr fetch request (read only)
//   instr_addr_i    in   32  fetch byte address
//   instr_gnt_o     out  1   instr request accepted this cycle (combinational)
//   instr_rvalid_o  out  1   instr read data valid
//   instr_rdata_o   out  32  instr read data
//   data_req_i      in   1   data request
//   data_we_i       in   1   1 = write, 0 = read
//   data_be_i       in   4   byte enables
//   data_addr_i     in   32  data byte address
//   data_wdata_i    in   32  write data
//   data_gnt_o      out  1   data request accepted this cycle (combinational)
//   data_rvalid_o   out  1   data response valid (reads and writes)
//   data_rdata_o    out  32  data read data
//   data_err_o      out  1   response error (address out of range), qualified by data_rvalid_o
//   mem_req_o       out  1   SRAM access strobe
//   mem_we_o        out  1   SRAM write enable
//   mem_be_o        out  4   SRAM byte enables
//   mem_addr_o      out  AW  SRAM word address
//   mem_wdata_o     out  32  SRAM write data
//   mem_rdata_i     in   32  SRAM read data, valid the cycle after mem_req_o (1-cycle latency)
//   conflict_cnt_o  out  16  count of cycles with instr_req_i & data_req_i both high, saturating
// BEHAVIOUR
//   Reset: all gnt/rvalid/err/mem_* outputs 0, rdata outputs 0, wait_cnt=0, rsp_owner=NONE,
//     conflict_cnt_o=0. While rst is high, gnt outputs are held 0. A response pending when
//     rst asserts is dropped and never issued.
//   Arbitration (combinational, same cycle as req): at most one gnt per cycle.
//     - Only one requester: that requester is granted.
//     - Both requesters: data is granted, unless wait_cnt==MAX_WAIT, then instr is granted.
//   wait_cnt (4b): +1 when instr_req_i & !instr_gnt_o; cleared on instr grant or instr_req_i low.
//   Range check: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*MEM_WORDS).
//     mem_addr_o = (addr - BASE_ADDR) >> 2 (addr[1:0] ignored). A granted in-range access drives
//     mem_req_o=1; a granted out-of-range access drives mem_req_o=0 (SRAM untouched).
//     Instr fetches are always reads: mem_we_o=0, mem_be_o=4'hF.
//   Response FSM, register rsp_owner in {NONE, INSTR, DATA} plus rsp_err, loaded every cycle:
//     - Instr grant -> INSTR. Data grant -> DATA. No grant -> NONE.
//     - rsp_err = granted access out of range.
//     - In INSTR: instr_rvalid_o=1; instr_rdata_o = mem_rdata_i, or 32'h0 if rsp_err (an illegal
//       instruction, so the core traps).
//     - In DATA: data_rvalid_o=1; data_err_o=rsp_err; data_rdata_o = mem_rdata_i for an in-range
//       read, else 32'h0. Writes also return rvalid.
//     - rvalid is exactly 1 cycle after gnt, so back-to-back grants give rvalid every cycle.
//   Ordering: responses leave in grant order; no buffering is needed because latency is fixed at 1.
//   conflict_cnt_o: +1 on every cycle with both reqs high; holds at 16'hFFFF.
// TESTING
//   1 Reset: rst=1 mid-access (gnt issued prior cycle) -> no rvalid next cycle; all outputs 0.
//   2 Instr only: req addr 0x10, SRAM word4=0x00500093 -> gnt same cycle, mem_addr=4,
//     instr_rvalid next cycle with rdata 0x00500093.
//   3 Data write/read: write 0xDEADBEEF be=4'b0011 @0x20, then read @0x20 -> write rvalid err=0;
//     read returns 0x0000BEEF (SRAM preset 0).
//   4 Contention: both reqs held high 10 cycles, MAX_WAIT=4 -> data gnt 4 cycles, instr gnt on the
//     5th, repeating; conflict_cnt_o=10.
//   5 Out of range: data read @BASE_ADDR+4*MEM_WORDS -> gnt, mem_req_o=0, next cycle rvalid
//     err=1 rdata=0. Instr fetch out of range -> instr_rdata_o=0.
//   6 Saturation: force 70000 conflict cycles -> conflict_cnt_o stays at 16'hFFFF.

Source files
------------

// File: rtl/gmsk_v1_mem_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch and data OBI ports of the core.
// Fixed data priority with an instruction anti-starvation timer and a 1-cycle response path.
module gmsk_v1_mem_arbiter #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 4,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,

  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,

  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,

  output logic [15:0]   conflict_cnt_o
);

  typedef enum logic [1:0] {RspNone, RspInstr, RspData} rsp_owner_e;

  rsp_owner_e  rsp_owner_q, rsp_owner_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_we_q, rsp_we_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] conflict_q, conflict_d;

  logic        starve;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic [31:0] offset;
  logic        sel_in_range;
  logic        unused_offset_bits;

  assign starve = (wait_q == 4'(MAX_WAIT));

  // Grants are forced low while reset is held, even though they are combinational.
  always_comb begin
    instr_gnt_o = !rst && instr_req_i && (!data_req_i || starve);
    data_gnt_o  = !rst && data_req_i && !instr_gnt_o;
    any_gnt     = instr_gnt_o || data_gnt_o;
  end

  // Range check done with a 33-bit upper bound so a base near the top of the map cannot wrap.
  always_comb begin
    sel_addr     = instr_gnt_o ? instr_addr_i : data_addr_i;
    offset       = sel_addr - BASE_ADDR;
    sel_in_range = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < (33'(MEM_WORDS) << 2));
  end

  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

  always_comb begin
    mem_req_o   = any_gnt && sel_in_range;
    mem_we_o    = data_gnt_o && data_we_i;
    mem_addr_o  = any_gnt ? offset[AW+1:2] : '0;
    mem_wdata_o = data_gnt_o ? data_wdata_i : '0;
    mem_be_o    = '0;
    if (instr_gnt_o) begin
      mem_be_o = 4'hF;
    end else if (data_gnt_o) begin
      mem_be_o = data_be_i;
    end
  end

  always_comb begin
    wait_d = '0;
    if (instr_req_i && !instr_gnt_o) begin
      wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    end

    conflict_d = conflict_q;
    if (instr_req_i && data_req_i && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_comb begin
    rsp_owner_d = RspNone;
    if (instr_gnt_o) begin
      rsp_owner_d = RspInstr;
    end else if (data_gnt_o) begin
      rsp_owner_d = RspData;
    end
    rsp_err_d = any_gnt && !sel_in_range;
    rsp_we_d  = data_gnt_o && data_we_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner_q <= RspNone;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      wait_q      <= '0;
      conflict_q  <= '0;
    end else begin
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      wait_q      <= wait_d;
      conflict_q  <= conflict_d;
    end
  end

  // Out-of-range fetches return zero so the core takes an illegal-instruction trap.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;
    unique case (rsp_owner_q)
      RspInstr: begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = rsp_err_q ? 32'h0 : mem_rdata_i;
      end
      RspData: begin
        data_rvalid_o = 1'b1;
        data_err_o    = rsp_err_q;
        data_rdata_o  = (!rsp_err_q && !rsp_we_q) ? mem_rdata_i : 32'h0;
      end
      default: ;
    endcase
  end

  assign conflict_cnt_o = conflict_q;

endmodule
